// File: rtl/hub75_bcm_scheduler.sv
// HUB75 frame/row/bit-plane sequencer using binary-coded modulation (LSB plane first).
// Define HUB75_BRIGHTNESS_EN to add i_brightness, which trims the OE-on part of each window.
module hub75_bcm_scheduler #(
  parameter int unsigned hpixel_p   = 64,
  parameter int unsigned vpixel_p   = 64,
  parameter int unsigned bpp_p      = 8,
  parameter int unsigned segments_p = 2,
  parameter int unsigned oe_base_p  = 16,
  parameter int unsigned dead_p     = 4
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic                                   i_enable,
  input  logic                                   i_tx_ready,
`ifdef HUB75_BRIGHTNESS_EN
  input  logic [7:0]                             i_brightness,
`endif
  output logic                                   o_tx_start,
  output logic [$clog2(hpixel_p*vpixel_p)-1:0]   o_init_addr,
  output logic [$clog2(bpp_p)-1:0]               o_pix_bit,
  output logic [$clog2(vpixel_p/segments_p)-1:0] o_row_addr,
  output logic                                   o_oe_n,
  output logic                                   o_frame_start,
  output logic                                   o_busy
);

  localparam int unsigned rows_p = vpixel_p / segments_p;
  localparam int unsigned AddrW  = $clog2(hpixel_p * vpixel_p);
  localparam int unsigned PixW   = $clog2(bpp_p);
  localparam int unsigned RowW   = $clog2(rows_p);
  localparam int unsigned WinW   = $clog2(oe_base_p) + bpp_p;
  localparam int unsigned DeadW  = $clog2(dead_p) + 1;
  localparam int unsigned CntW   = (WinW > DeadW) ? WinW : DeadW;

  typedef enum logic [2:0] {
    StIdle,
    StBlank,
    StShift,
    StWaitBusy,
    StWaitDone,
    StDisplay
  } state_e;

  state_e            state_q;
  logic [RowW-1:0]   row_q;
  logic [PixW-1:0]   bit_q;
  logic [CntW-1:0]   cnt_q;
  logic [CntW-1:0]   win_q;
  logic [CntW-1:0]   on_q;

  logic [CntW-1:0]   win_nxt;
  logic [CntW-1:0]   on_nxt;

  // Window doubles per bit plane; sized so the MSB plane cannot overflow.
  assign win_nxt = CntW'(oe_base_p) << bit_q;

`ifdef HUB75_BRIGHTNESS_EN
  localparam int unsigned ProdW = CntW + 9;
  logic [ProdW-1:0] on_prod;
  assign on_prod = ProdW'(win_nxt) * ProdW'({1'b0, i_brightness} + 9'd1);
  assign on_nxt  = CntW'(on_prod >> 8);
`else
  assign on_nxt  = win_nxt;
`endif

  function automatic logic [AddrW-1:0] row_base(input logic [RowW-1:0] r);
    return AddrW'(hpixel_p * 32'(r));
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= StIdle;
      row_q         <= '0;
      bit_q         <= '0;
      cnt_q         <= '0;
      win_q         <= '0;
      on_q          <= '0;
      o_tx_start    <= 1'b0;
      o_init_addr   <= '0;
      o_pix_bit     <= '0;
      o_row_addr    <= '0;
      o_oe_n        <= 1'b1;
      o_frame_start <= 1'b0;
      o_busy        <= 1'b0;
    end else begin
      o_tx_start    <= 1'b0;
      o_frame_start <= 1'b0;
      unique case (state_q)
        StIdle: begin
          o_oe_n <= 1'b1;
          if (i_enable) begin
            state_q       <= StBlank;
            row_q         <= '0;
            bit_q         <= '0;
            cnt_q         <= '0;
            o_row_addr    <= '0;
            o_init_addr   <= '0;
            o_frame_start <= 1'b1;
            o_busy        <= 1'b1;
          end
        end

        StBlank: begin
          if (cnt_q == CntW'(dead_p - 1)) begin
            state_q   <= StShift;
            cnt_q     <= '0;
            o_pix_bit <= bit_q;
          end else begin
            cnt_q <= cnt_q + CntW'(1);
          end
        end

        // Start only goes out after ready was seen high, so it never meets a busy transmitter.
        StShift: begin
          if (i_tx_ready) begin
            o_tx_start <= 1'b1;
            state_q    <= StWaitBusy;
          end
        end

        StWaitBusy: begin
          if (!i_tx_ready) state_q <= StWaitDone;
        end

        StWaitDone: begin
          if (i_tx_ready) begin
            state_q <= StDisplay;
            cnt_q   <= '0;
            win_q   <= win_nxt;
            on_q    <= on_nxt;
            o_oe_n  <= (on_nxt == '0);
          end
        end

        StDisplay: begin
          if (cnt_q == win_q - CntW'(1)) begin
            o_oe_n <= 1'b1;
            cnt_q  <= '0;
            if (!i_enable) begin
              state_q     <= StIdle;
              row_q       <= '0;
              bit_q       <= '0;
              o_pix_bit   <= '0;
              o_row_addr  <= '0;
              o_init_addr <= '0;
              o_busy      <= 1'b0;
            end else if (bit_q != PixW'(bpp_p - 1)) begin
              bit_q     <= bit_q + 1'b1;
              o_pix_bit <= bit_q + 1'b1;
              state_q   <= StShift;
            end else begin
              bit_q   <= '0;
              state_q <= StBlank;
              if (row_q != RowW'(rows_p - 1)) begin
                row_q       <= row_q + 1'b1;
                o_row_addr  <= row_q + 1'b1;
                o_init_addr <= row_base(row_q + 1'b1);
              end else begin
                row_q         <= '0;
                o_row_addr    <= '0;
                o_init_addr   <= '0;
                o_frame_start <= 1'b1;
              end
            end
          end else begin
            cnt_q  <= cnt_q + CntW'(1);
            o_oe_n <= !((cnt_q + CntW'(1)) < on_q);
          end
        end

        default: begin
          state_q <= StIdle;
          o_oe_n  <= 1'b1;
          o_busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_hub75_bcm_scheduler.sv
// Bench for hub75_bcm_scheduler: a plane-sequence model checked every cycle plus literal timing pins.
module tb_hub75_bcm_scheduler;

  localparam int HP   = 4;
  localparam int VP   = 4;
  localparam int SEG  = 2;
  localparam int BPP  = 2;
  localparam int OEB  = 2;
  localparam int DEAD = 2;
  localparam int ROWS = VP / SEG;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       i_enable = 1'b0;
  logic       i_tx_ready;
  logic       o_tx_start;
  logic [3:0] o_init_addr;
  logic [0:0] o_pix_bit;
  logic [0:0] o_row_addr;
  logic       o_oe_n;
  logic       o_frame_start;
  logic       o_busy;
`ifdef HUB75_BRIGHTNESS_EN
  logic [7:0] br = 8'd255;
`endif

  hub75_bcm_scheduler #(
    .hpixel_p  (HP),
    .vpixel_p  (VP),
    .bpp_p     (BPP),
    .segments_p(SEG),
    .oe_base_p (OEB),
    .dead_p    (DEAD)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .i_enable     (i_enable),
    .i_tx_ready   (i_tx_ready),
`ifdef HUB75_BRIGHTNESS_EN
    .i_brightness (br),
`endif
    .o_tx_start   (o_tx_start),
    .o_init_addr  (o_init_addr),
    .o_pix_bit    (o_pix_bit),
    .o_row_addr   (o_row_addr),
    .o_oe_n       (o_oe_n),
    .o_frame_start(o_frame_start),
    .o_busy       (o_busy)
  );

  always #5 clk = ~clk;

  // Transmitter: ready drops the cycle after start and returns 10 cycles later.
  logic tx_rdy_q;
  int   tx_cnt;
  logic hold_low = 1'b0;
  always @(posedge clk) begin
    if (rst) begin
      tx_rdy_q <= 1'b1;
      tx_cnt   <= 0;
    end else if (o_tx_start && tx_rdy_q) begin
      tx_rdy_q <= 1'b0;
      tx_cnt   <= 10;
    end else if (tx_cnt > 0) begin
      tx_cnt <= tx_cnt - 1;
      if (tx_cnt == 1) tx_rdy_q <= 1'b1;
    end
  end
  assign i_tx_ready = tx_rdy_q && !hold_low;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  bit chk_on = 1'b0;
  bit e_oe, e_start, e_fs, e_busy;
  int e_pix, e_row, e_addr;
  bit en_s, rdy_s;
  int br_s;

  task automatic set_exp(input bit oe, input bit st, input bit fs, input bit busy);
    e_oe = oe; e_start = st; e_fs = fs; e_busy = busy;
  endtask

  task automatic tick(output bit r);
    @(posedge clk);
    r     = rst;
    en_s  = i_enable;
    rdy_s = i_tx_ready;
`ifdef HUB75_BRIGHTNESS_EN
    br_s  = int'(br);
`else
    br_s  = 255;
`endif
  endtask

  // Walks the frame as rows x planes; returns on reset or on a return to idle.
  task automatic model_run();
    bit r;
    int row, w, on;
    bit fs;
    forever begin
      tick(r);
      if (r) return;
      if (en_s) break;
    end
    row = 0;
    fs  = 1'b1;
    forever begin
      for (int i = 0; i < DEAD; i++) begin
        set_exp(1'b1, 1'b0, fs && (i == 0), 1'b1);
        e_row  = row;
        e_addr = row * HP;
        tick(r);
        if (r) return;
      end
      for (int pb = 0; pb < BPP; pb++) begin
        e_pix = pb;
        set_exp(1'b1, 1'b0, 1'b0, 1'b1);
        forever begin
          tick(r);
          if (r) return;
          if (rdy_s) break;
        end
        set_exp(1'b1, 1'b1, 1'b0, 1'b1);
        do begin
          tick(r);
          if (r) return;
          set_exp(1'b1, 1'b0, 1'b0, 1'b1);
        end while (rdy_s);
        do begin
          tick(r);
          if (r) return;
        end while (!rdy_s);
        w  = OEB << pb;
        on = (w * (br_s + 1)) >> 8;
        for (int c = 0; c < w; c++) begin
          set_exp(c >= on, 1'b0, 1'b0, 1'b1);
          tick(r);
          if (r) return;
        end
        if (!en_s) return;
      end
      row = (row + 1) % ROWS;
      fs  = (row == 0);
    end
  endtask

  initial begin
    do @(posedge clk); while (!rst);
    forever begin
      set_exp(1'b1, 1'b0, 1'b0, 1'b0);
      e_pix  = 0;
      e_row  = 0;
      e_addr = 0;
      chk_on = 1'b1;
      model_run();
    end
  end

  // ---------------- compare + monitors ----------------
  int run_len = 0;
  int runs[$];
  int st_row[$], st_addr[$], st_pix[$];
  int fs_count = 0, fs_cyc = -1, st_cyc = -1;

  initial forever begin
    @(negedge clk);
    if (chk_on) begin
      check("oe_n", int'(o_oe_n), int'(e_oe));
      check("tx_start", int'(o_tx_start), int'(e_start));
      check("frame_start", int'(o_frame_start), int'(e_fs));
      check("busy", int'(o_busy), int'(e_busy));
      if (e_busy) begin
        check("pix_bit", int'(o_pix_bit), e_pix);
        check("row_addr", int'(o_row_addr), e_row);
        check("init_addr", int'(o_init_addr), e_addr);
      end
      if (!i_tx_ready) check("oe_off_while_tx_busy", int'(o_oe_n), 1);
      if (o_tx_start) check("start_only_when_ready", int'(i_tx_ready), 1);
      if (o_oe_n == 1'b0) begin
        run_len++;
      end else if (run_len > 0) begin
        runs.push_back(run_len);
        run_len = 0;
      end
      if (o_frame_start) begin
        fs_count++;
        if (fs_count == 1) fs_cyc = cyc;
      end
      if (o_tx_start) begin
        if (st_cyc < 0) st_cyc = cyc;
        st_row.push_back(int'(o_row_addr));
        st_addr.push_back(int'(o_init_addr));
        st_pix.push_back(int'(o_pix_bit));
      end
    end
  end

  // ---------------- directed stimulus ----------------
  int exp_rows[5]  = '{0, 0, 1, 1, 0};
  int exp_addrs[5] = '{0, 0, 4, 4, 0};
  int exp_pixs[5]  = '{0, 1, 0, 1, 0};
  int exp_runs[4]  = '{2, 4, 2, 4};

  initial begin
    int n, p, cnt;
    logic prev;
    repeat (3) @(negedge clk);
    i_enable = 1'b1;
    rst = 1'b0;

    // First frame: timing, row advance and frame wrap.
    for (int i = 0; i < 400 && st_row.size() < 5; i++) @(negedge clk);
    check("frame1_tx_starts", st_row.size(), 5);
    if (st_row.size() >= 5) begin
      for (int i = 0; i < 5; i++) begin
        check("start_row", st_row[i], exp_rows[i]);
        check("start_addr", st_addr[i], exp_addrs[i]);
        check("start_pix", st_pix[i], exp_pixs[i]);
      end
    end
    check("frame_start_count", fs_count, 2);
    check("fs_to_first_start", st_cyc - fs_cyc, 3);
    check("oe_runs_seen", (runs.size() >= 4) ? 1 : 0, 1);
    if (runs.size() >= 4)
      for (int i = 0; i < 4; i++) check("oe_run_len", runs[i], exp_runs[i]);

    // Hold ready low across a shift.
    prev = o_oe_n;
    n = 0;
    do begin
      prev = o_oe_n;
      @(negedge clk);
      n++;
    end while (!(prev == 1'b0 && o_oe_n == 1'b1) && n < 200);
    check("display_end_seen", (n < 200) ? 1 : 0, 1);
    hold_low = 1'b1;
    cnt = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (o_tx_start) cnt++;
    end
    check("starts_while_held", cnt, 0);
    hold_low = 1'b0;
    cnt = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (o_tx_start) cnt++;
    end
    check("starts_after_release", cnt, 1);

    // Drop enable mid-shift: the plane completes, then idle.
    n = 0;
    while (!o_tx_start && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("start_for_disable", int'(o_tx_start), 1);
    p = int'(o_pix_bit);
    i_enable = 1'b0;
    n = 0;
    while (o_busy && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("idle_after_disable", int'(o_busy), 0);
    @(negedge clk);
    @(negedge clk);
    check("last_plane_run", (runs.size() > 0) ? runs[$] : -1, OEB << p);
    cnt = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (o_busy || !o_oe_n) cnt++;
    end
    check("stays_idle", cnt, 0);

    // Reset during DISPLAY.
`ifdef HUB75_BRIGHTNESS_EN
    br = 8'd127;
`endif
    i_enable = 1'b1;
    n = 0;
    while (o_oe_n && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("display_before_reset", int'(o_oe_n), 0);
    rst = 1'b1;
    @(negedge clk);
    check("oe_off_after_reset", int'(o_oe_n), 1);
    check("busy_off_after_reset", int'(o_busy), 0);
    rst = 1'b0;
    @(negedge clk);
    @(negedge clk);
    runs.delete();

`ifdef HUB75_BRIGHTNESS_EN
    for (int i = 0; i < 300 && runs.size() < 2; i++) @(negedge clk);
    check("bright_runs_seen", runs.size(), 2);
    if (runs.size() >= 2) begin
      check("bright127_bit0", runs[0], 1);
      check("bright127_bit1", runs[1], 2);
    end
    br = 8'd0;
    cnt = 0;
    for (int i = 0; i < 120; i++) begin
      @(negedge clk);
      if (!o_oe_n) cnt++;
    end
    check("bright0_oe_low_cycles", cnt, 0);
`else
    repeat (60) @(negedge clk);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/hub75_bcm_scheduler.md
Name: hub75_bcm_scheduler

Overview:
Frame/row/bit-plane sequencer for a HUB75 panel using binary-coded modulation (BCM).
- Drives the colour-shift transmitter control port: start, initial address, pixel bit.
- Drives the panel row address and active-low output enable, weighting on-time per bit plane.
- Sits between the top-level config and the colour-shift transmitter; runs continuously while enabled.

Parameters:
- hpixel_p, 64, display width in pixels.
- vpixel_p, 64, display height in pixels.
- bpp_p, 8, bits per colour channel (number of bit planes).
- segments_p, 2, display segments; rows_p = vpixel_p/segments_p rows are scanned.
- oe_base_p, 16, OE-on cycles for bit plane 0 (LSB).
- dead_p, 4, OE-off dead-time cycles at each row change (≥1).

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous reset, active-high.
- i_enable  in  1  run scheduler.
- i_tx_ready  in  1  transmitter idle/ready (high = idle, registered in transmitter).
- o_tx_start  out  1  one-cycle start pulse to transmitter.
- o_init_addr  out  $clog2(hpixel_p*vpixel_p)  first pixel address of current row = row*hpixel_p.
- o_pix_bit  out  $clog2(bpp_p)  bit plane being shifted.
- o_row_addr  out  $clog2(rows_p)  panel row address (A..E).
- o_oe_n  out  1  panel output enable, active-low.
- o_frame_start  out  1  one-cycle pulse at start of each frame.
- o_busy  out  1  high whenever state ≠ IDLE.

Behaviour:
- Reset values (all outputs registered):
  - o_tx_start=0, o_init_addr=0, o_pix_bit=0, o_row_addr=0.
  - o_oe_n=1, o_frame_start=0, o_busy=0.
  - State IDLE; internal row=0, bit=0.
- States: IDLE, BLANK, SHIFT, WAIT_BUSY, WAIT_DONE, DISPLAY.
- IDLE:
  - o_oe_n=1.
  - If i_enable=1, go to BLANK with row=0, bit=0, and pulse o_frame_start in the first BLANK cycle.
- BLANK:
  - o_oe_n=1 for exactly dead_p cycles.
  - o_row_addr and o_init_addr update to the current row on the first BLANK cycle.
  - Then go to SHIFT.
- SHIFT:
  - o_pix_bit=bit, o_init_addr=row*hpixel_p, both held stable until the next SHIFT.
  - If i_tx_ready=1, assert o_tx_start for exactly one cycle and go to WAIT_BUSY.
  - Else stay in SHIFT with o_tx_start=0. Start is never asserted while ready is low.
- WAIT_BUSY: stay until i_tx_ready=0, then go to WAIT_DONE.
- WAIT_DONE: stay until i_tx_ready=1 (shift and latch complete), then go to DISPLAY.
- DISPLAY:
  - o_oe_n=0 for exactly oe_base_p<<bit cycles; the counter is $clog2(oe_base_p)+bpp_p bits wide, with no overflow.
  - At window end o_oe_n=1, then:
    - i_enable=0 → IDLE (row and bit cleared).
    - else if bit<bpp_p-1 → bit+1, go to SHIFT (no dead-time).
    - else bit=0; if row<rows_p-1 → row+1, go to BLANK.
    - else row=0, go to BLANK and pulse o_frame_start (frame wrap).
- OE is high in every state except DISPLAY; OE is never low during shift/latch or during a row change.
- i_enable is sampled only in IDLE and at DISPLAY end. Deasserting it elsewhere completes the current plane first.
- Plane order: row-major, LSB plane first. Frame length = rows_p * (dead_p + Σ_b(shift_time + oe_base_p<<b)) plus handshake cycles.
- rst mid-operation: next cycle all outputs at reset values, state IDLE, OE off.
- A transmitter that never drops ready leaves the scheduler in WAIT_BUSY indefinitely, with OE off. This is the safe state; no timeout.

Optional Feature:
HUB75_BRIGHTNESS_EN
- With the macro: adds input i_brightness [7:0].
  - In DISPLAY, o_oe_n=0 only for the first ((oe_base_p<<bit)*(i_brightness+1))>>8 cycles, then high for the rest of the window.
  - Window length is unchanged.
  - i_brightness is sampled at DISPLAY entry.
  - A result of 0 keeps OE high for the whole window.
- Without the macro: no port; full-window OE (equivalent to brightness 255).

Test Plan:
Test parameters: hpixel_p=4, vpixel_p=4, segments_p=2, bpp_p=2, oe_base_p=2, dead_p=2; transmitter model drops ready 1 cycle after start and raises it 10 cycles later.
1. Reset, enable=1 → o_frame_start pulse in cycle 1; o_oe_n=1 for 2 cycles; o_tx_start with o_init_addr=0, o_pix_bit=0.
2. Plane timing → row 0 OE-low runs of 2 cycles (bit 0) then 4 cycles (bit 1); OE high throughout every shift.
3. Row advance → after row 0 bit 1, BLANK of 2 cycles; o_row_addr=1, o_init_addr=4; then frame wraps to row 0 with a second o_frame_start.
4. Hold i_tx_ready=0 in SHIFT for 5 cycles → o_tx_start stays 0 and is pulsed once on the cycle ready returns.
5. Deassert enable mid-shift → current plane completes its DISPLAY, then IDLE with o_busy=0, o_oe_n=1; assert rst mid-DISPLAY → o_oe_n=1 on the next cycle.
6. HUB75_BRIGHTNESS_EN, i_brightness=127, bit 1 → OE low 2 of 4 cycles; i_brightness=0 → OE never low.
